// File: rtl/bcd_round_timer.sv
// rtl/bcd_round_timer.sv - multi-digit BCD round timer with seven-segment decode
//
// Counts up or down in BCD on a tick strobe between 0 and MAX_VALUE, with
// load, pause/resume, and wrap or finish behaviour at the bound. Drives one
// active-low seven-segment pattern per digit.
//
// Parameters:
//   DIGITS        number of BCD digits (1-4)
//   MAX_VALUE     terminal count as an integer, < 10**DIGITS
//   BLANK_LEADING 1 blanks zero digits above the highest non-zero digit
//
// Ports:
//   clk       system clock, rising edge
//   clear_b   asynchronous active-low reset
//   tick      count strobe, honoured only in RUN
//   start     load load_val (or MAX_VALUE if invalid) and enter RUN
//   stop      pause/resume toggle strobe
//   dir       0 = up, 1 = down
//   wrap      1 = wrap at the bound, 0 = finish at the bound
//   load_val  BCD start value, digit k at [4k+3:4k]
//   count     current BCD value
//   hex       segment patterns, digit k at [7k+6:7k], bit 6 = a .. bit 0 = g
//   running   high in RUN
//   done      high in DONE
//   tc_pulse  one-cycle terminal-count pulse

module bcd_round_timer #(
  parameter int DIGITS        = 2,
  parameter int MAX_VALUE     = 20,
  parameter int BLANK_LEADING = 0
) (
  input  logic                  clk,
  input  logic                  clear_b,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  input  logic                  wrap,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  running,
  output logic                  done,
  output logic                  tc_pulse
);

  localparam int W = 4 * DIGITS;

  // Elaboration-time conversion of the integer bound to BCD so that all
  // run-time arithmetic stays digit-wise.
  function automatic logic [W-1:0] to_bcd(input int v);
    int r;
    r = v;
    to_bcd = '0;
    for (int k = 0; k < DIGITS; k++) begin
      to_bcd[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
  endfunction

  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);

  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic c;
    c = 1'b1;
    bcd_inc = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (c) begin
        if (v[4*k +: 4] == 4'd9) begin
          bcd_inc[4*k +: 4] = 4'd0;
        end else begin
          bcd_inc[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic b;
    b = 1'b1;
    bcd_dec = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          bcd_dec[4*k +: 4] = 4'd9;
        end else begin
          bcd_dec[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   count_n;
  logic           tc_n;
  logic           load_ok;
  logic [W-1:0]   bound;
  logic [W-1:0]   stepped;

  // Both operands are valid BCD once every digit is <= 9, so a plain
  // unsigned compare of the packed vectors orders them numerically.
  always_comb begin
    load_ok = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9) load_ok = 1'b0;
    end
    if (load_val > MAX_BCD) load_ok = 1'b0;
  end

  always_comb begin
    state_n = state;
    count_n = count;
    tc_n    = 1'b0;
    bound   = dir ? '0 : MAX_BCD;
    stepped = dir ? bcd_dec(count) : bcd_inc(count);

    if (start) begin
      count_n = load_ok ? load_val : MAX_BCD;
      state_n = RUN;
    end else if (stop) begin
      if (state == RUN)        state_n = PAUSE;
      else if (state == PAUSE) state_n = RUN;
    end else if (tick && state == RUN) begin
      if (count != bound) begin
        count_n = stepped;
        if (stepped == bound) begin
          tc_n = 1'b1;
          if (!wrap) state_n = DONE;
        end
      end else if (wrap) begin
        // Wrapping from the bound is not a terminal event: no pulse.
        count_n = dir ? MAX_BCD : '0;
      end else begin
        // Sitting on the bound already (e.g. loaded there): finish now.
        state_n = DONE;
        tc_n    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      state    <= IDLE;
      count    <= '0;
      tc_pulse <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      tc_pulse <= tc_n;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

  // Scan from the most-significant digit; a digit is "leading" while every
  // digit above it, and itself, is zero. Digit 0 is always shown.
  always_comb begin
    logic       lead;
    logic [3:0] d;
    hex  = '1;
    lead = 1'b1;
    d    = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      d = count[4*k +: 4];
      if (d != 4'd0) lead = 1'b0;
      if (BLANK_LEADING != 0 && lead && k != 0) hex[7*k +: 7] = 7'b1111111;
      else                                      hex[7*k +: 7] = seg(d);
    end
  end

endmodule
